// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: one round key per EMIT, SubWord done externally.
// Optional AES_KS_ABORT_EN adds an abort input that drops any schedule back to IDLE.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int SUB_LAT    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
`ifdef AES_KS_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} state_t;

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [3:0]  round;
  logic [31:0] rcon_q;
  logic [1:0]  sub_cnt;
  logic [31:0] sub_q;
  logic [31:0] nw0, nw1, nw2, nw3;
  logic        abort_hit;

`ifdef AES_KS_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // Chained XOR: each new word depends on the new word before it.
  assign nw0 = w0 ^ sub_q ^ rcon_q;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      round     <= '0;
      rcon_q    <= '0;
      sub_cnt   <= '0;
      sub_q     <= '0;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_round  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      key_ready <= 1'b1;
      sub_in    <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state     <= IDLE;
        w0        <= '0;
        w1        <= '0;
        w2        <= '0;
        w3        <= '0;
        round     <= '0;
        rcon_q    <= '0;
        sub_cnt   <= '0;
        rk_valid  <= 1'b0;
        rk_data   <= '0;
        rk_round  <= '0;
        busy      <= 1'b0;
        key_ready <= 1'b1;
        sub_in    <= '0;
      end else begin
        case (state)
          IDLE: if (key_valid && key_ready) begin
            {w0, w1, w2, w3} <= key_in;
            round     <= '0;
            rk_valid  <= 1'b1;
            rk_data   <= key_in;
            rk_round  <= '0;
            busy      <= 1'b1;
            key_ready <= 1'b0;
            state     <= EMIT;
          end
          EMIT: if (rk_ready) begin
            rk_valid <= 1'b0;
            if (round == 4'(NUM_ROUNDS)) begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              key_ready <= 1'b1;
            end else begin
              round   <= round + 4'd1;
              sub_cnt <= '0;
              sub_in  <= {w3[23:0], w3[31:24]};
              state   <= SUB;
            end
          end
          SUB: begin
            // round was already advanced on leaving EMIT
            if (sub_cnt == 2'd0) rcon_q <= {rcon_of(round), 24'h0};
            if (sub_cnt == 2'(SUB_LAT)) begin
              sub_q  <= sub_out;
              sub_in <= '0;
              state  <= MIX;
            end else begin
              sub_cnt <= sub_cnt + 2'd1;
            end
          end
          MIX: begin
            w0       <= nw0;
            w1       <= nw1;
            w2       <= nw2;
            w3       <= nw3;
            rk_valid <= 1'b1;
            rk_data  <= {nw0, nw1, nw2, nw3};
            rk_round <= round;
            state    <= EMIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
